word_uart_tx: RTL and testbench
===============================

WORD_UART_TX -- requirements
Module: word_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 Parameter HEADER, default 8'hA5, sync byte sent before each word.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 UART_go  input  1  level request from the memory controller: send data_in.
REQ-006 data_in  input  90  word to transmit; valid from the second cycle of UART_go high.
REQ-007 tx  output  1  serial line, 8N1, idle high.
REQ-008 UART_done  output  1  one-cycle pulse: word fully sent.
REQ-009 busy  output  1  high from LOAD through DONE inclusive.
REQ-010 byte_idx  output  4  index of the byte currently on the line, 0 = header (debug).

Function
REQ-011 The FSM SHALL use states IDLE, LOAD, START, DATA, STOP, NEXT, DONE, WAIT_LOW.
REQ-012 IDLE: tx=1; UART_go=1 -> LOAD next cycle.
REQ-013 LOAD: one cycle; capture data_in into a 96-bit shift buffer, with bits 95:90 forced to 0; byte_idx:=0; -> START. This covers the one-cycle BRAM read latency upstream.
REQ-014 Frame SHALL be 13 bytes: HEADER, then buffer bytes 7:0, 15:8, ..., 95:88 (LS byte first).
REQ-015 Each byte SHALL be sent as a start bit (0), 8 data bits LSB first, and a stop bit (1); each bit lasts exactly CLKS_PER_BIT cycles.
REQ-016 States START, DATA, and STOP SHALL each hold their bit for CLKS_PER_BIT cycles using a bit-timer counter; DATA SHALL use a 3-bit bit counter and exit after bit 7.
REQ-017 NEXT: one cycle, tx=1; if byte_idx==12 -> DONE, else byte_idx+1 -> START. This inserts one extra idle cycle between bytes.
REQ-018 DONE: UART_done=1 for exactly one cycle; -> WAIT_LOW.
REQ-019 WAIT_LOW: wait until UART_go==0, then -> IDLE. A held-high UART_go SHALL NOT retrigger a send; each word needs a low-then-high on UART_go.
REQ-020 Total latency from the LOAD cycle to the UART_done cycle SHALL equal 1 + 13*(10*CLKS_PER_BIT + 1) cycles.
REQ-021 UART_go falling mid-frame SHALL NOT abort the frame; it completes, UART_done pulses, and WAIT_LOW exits on the next cycle.
REQ-022 data_in changes after LOAD SHALL NOT affect the frame in flight.
REQ-023 Back-to-back operation: with UART_go low for one cycle after UART_done and then high again, the next word SHALL start with no lost request.
REQ-024 The bit timer SHALL be sized as clog2(CLKS_PER_BIT) bits and wrap to 0 at CLKS_PER_BIT-1; it SHALL NOT overflow.

Reset
REQ-025 When reset=0 at a clock edge: state=IDLE, tx=1, UART_done=0, busy=0, byte_idx=0, timers=0, buffer=0, effective the next cycle.
REQ-026 Reset mid-byte SHALL drive tx high immediately after the reset edge; a truncated frame is acceptable, and no UART_done SHALL be issued.

Structure
REQ-027 Package word_uart_tx_pkg SHALL hold the state encoding, NUM_BYTES=13, WORD_W=90, and BUF_W=96.
REQ-028 Sub-module uart_byte_tx (byte load/start, serializer, bit timer, byte_done) is natural; word_uart_tx then sequences the header and the buffer bytes.
REQ-029 All outputs SHALL be registered; tx SHALL be glitch-free.

Verification (CLKS_PER_BIT=4)
REQ-030 data_in=90'h1 with UART_go held -> decoded bytes A5,01, then eleven 00; UART_done exactly at the REQ-020 cycle count (534).
REQ-031 data_in all ones -> bytes A5, eleven FF, then 03; every bit period measured as 4 cycles.
REQ-032 UART_go held high after UART_done -> no second frame, tx stays 1 for 100 cycles; then drop UART_go 1 cycle and raise it -> second frame starts.
REQ-033 data_in changed and UART_go dropped during byte 5 -> frame carries the LOAD-time value; single UART_done; then IDLE.
REQ-034 reset=0 asserted during byte 3 -> tx=1, busy=0 the next cycle, no UART_done; a subsequent request sends a clean full frame.
REQ-035 Integration with the memory controller and a 100-word BRAM image -> 100 frames received in address order, controller returns to IDLE.

Source files
------------

// File: rtl/word_uart_tx_pkg.sv
// Shared constants and FSM encoding for the word-oriented UART transmitter.
package word_uart_tx_pkg;
  localparam int NUM_BYTES = 13;
  localparam int WORD_W    = 90;
  localparam int BUF_W     = 96;

  typedef enum logic [2:0] {
    IDLE, LOAD, START, DATA, STOP, NEXT, DONE, WAIT_LOW
  } state_e;
endpackage

// File: rtl/uart_byte_tx.sv
// Per-byte serializer datapath: bit timer, data-bit counter and byte shifter,
// sequenced by the word FSM state. next_bit_o is the data bit for the next cycle.
module uart_byte_tx
  import word_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  state_e     state_i,
  input  logic [7:0] byte_i,
  output logic       bit_end_o,
  output logic       last_bit_o,
  output logic       next_bit_o
);
  localparam int            TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          in_bit;

  always_comb begin
    in_bit     = state_i inside {START, DATA, STOP};
    bit_end_o  = in_bit && (tmr_q == TMAX);
    last_bit_o = (bit_q == 3'd7);
    tmr_d      = '0;
    bit_d      = '0;
    sh_d       = sh_q;
    if (in_bit && !bit_end_o) tmr_d = tmr_q + 1'b1;
    // Byte is (re)loaded throughout START so the first data bit is ready on exit.
    if (state_i == START) sh_d = byte_i;
    if (state_i == DATA) begin
      bit_d = bit_q;
      if (bit_end_o) begin
        bit_d = bit_q + 3'd1;
        sh_d  = {1'b0, sh_q[7:1]};
      end
    end
    next_bit_o = sh_d[0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tmr_q <= '0;
      bit_q <= '0;
      sh_q  <= '0;
    end else begin
      tmr_q <= tmr_d;
      bit_q <= bit_d;
      sh_q  <= sh_d;
    end
  end
endmodule

// File: rtl/word_uart_tx.sv
// Sends a 90-bit word as a 13-byte 8N1 frame: HEADER, then the word LS byte first.
// All outputs are registered from the next state so tx never glitches.
module word_uart_tx
  import word_uart_tx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              UART_go,
  input  logic [WORD_W-1:0] data_in,
  output logic              tx,
  output logic              UART_done,
  output logic              busy,
  output logic [3:0]        byte_idx
);
  state_e           state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [3:0]       idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             done_q, busy_q;
  logic             bit_end, last_bit, next_bit;
  logic [7:0]       byte_sel;

  assign byte_sel = (idx_q == 4'd0) ? HEADER : buf_q[7:0];

  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk        (clk),
    .reset      (reset),
    .state_i    (state_q),
    .byte_i     (byte_sel),
    .bit_end_o  (bit_end),
    .last_bit_o (last_bit),
    .next_bit_o (next_bit)
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE:     if (UART_go) state_d = LOAD;
      LOAD: begin
        buf_d   = {{(BUF_W - WORD_W){1'b0}}, data_in};
        idx_d   = '0;
        state_d = START;
      end
      START:    if (bit_end) state_d = DATA;
      DATA:     if (bit_end && last_bit) state_d = STOP;
      STOP:     if (bit_end) state_d = NEXT;
      NEXT: begin
        // The header does not come from the buffer, so only shift after buffer bytes.
        if (idx_q != 4'd0) buf_d = {8'h00, buf_q[BUF_W-1:8]};
        if (idx_q == 4'(NUM_BYTES - 1)) state_d = DONE;
        else begin
          idx_d   = idx_q + 4'd1;
          state_d = START;
        end
      end
      DONE:     state_d = WAIT_LOW;
      WAIT_LOW: if (!UART_go) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    tx_d = 1'b1;
    if (state_d == START)     tx_d = 1'b0;
    else if (state_d == DATA) tx_d = next_bit;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= (state_d == DONE);
      busy_q  <= state_d inside {LOAD, START, DATA, STOP, NEXT, DONE};
    end
  end

  assign tx        = tx_q;
  assign UART_done = done_q;
  assign busy      = busy_q;
  assign byte_idx  = idx_q;
endmodule

// File: tb/tb_word_uart_tx.sv
// Bench for word_uart_tx at 4 clocks/bit: serial decoder feeding a byte scoreboard.
module tb_word_uart_tx;
  localparam int CPB = 4;
  localparam int LAT = 1 + 13 * (10 * CPB + 1);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        UART_go = 1'b0;
  logic [89:0] data_in = '0;
  logic        tx, UART_done, busy;
  logic [3:0]  byte_idx;

  word_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
    .clk(clk), .reset(reset), .UART_go(UART_go), .data_in(data_in),
    .tx(tx), .UART_done(UART_done), .busy(busy), .byte_idx(byte_idx)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] b; logic [3:0] idx; } exp_t;
  typedef struct { logic [89:0] data; int lat; } vec_t;

  exp_t sbq[$];
  vec_t vecs[4];
  int   tests = 0, fails = 0;
  int   cyc = 0, load_cyc = 0, done_cnt = 0, done_wide = 0;
  logic busy_prev = 1'b0, done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy === 1'b1 && busy_prev !== 1'b1) load_cyc <= cyc;
    if (UART_done === 1'b1) done_cnt <= done_cnt + 1;
    if (UART_done === 1'b1 && done_prev === 1'b1) done_wide <= done_wide + 1;
    busy_prev <= busy;
    done_prev <= UART_done;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Serial decoder: every bit window of CPB cycles must hold one level.
  initial begin : rx_mon
    logic [9:0] bits;
    logic       stable, aborted;
    logic [3:0] idx0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        stable = 1'b1; aborted = 1'b0; idx0 = byte_idx; bits = '0;
        for (int b = 0; b < 10; b++)
          for (int k = 0; k < CPB; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (reset !== 1'b1) aborted = 1'b1;
            if (k == 0) bits[b] = tx;
            else if (tx !== bits[b]) stable = 1'b0;
          end
        if (!aborted) begin
          if (sbq.size() == 0) begin
            tests++; fails++;
            $display("FAIL rx_unexpected: got byte %02h, expected no byte", bits[8:1]);
          end else begin
            e = sbq.pop_front();
            chk("rx_byte", int'(bits[8:1]), int'(e.b));
            chk("rx_byte_idx", int'(idx0), int'(e.idx));
            chk("rx_framing_stop_start_stable", int'({bits[9], bits[0], stable}), 3'b101);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [89:0] d);
    logic [95:0] full;
    exp_t e;
    full = {6'b0, d};
    e.b = 8'hA5; e.idx = 4'd0;
    sbq.push_back(e);
    for (int k = 0; k < 12; k++) begin
      e.b = full[8*k +: 8]; e.idx = 4'(k + 1);
      sbq.push_back(e);
    end
  endtask

  // go rises with stale data; the word is only valid from the second cycle.
  task automatic request(input logic [89:0] d);
    UART_go = 1'b1; data_in = ~d;
    step(1);
    data_in = d;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int n = 0;
    @(negedge clk);
    while (UART_done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    if (UART_done !== 1'b1) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no UART_done, expected one within 2000 cycles", name);
    end else chk({name, "_latency"}, cyc - load_cyc, exp_lat);
  endtask

  task automatic wait_idx(input string name, input logic [3:0] idx);
    int n = 0;
    while (byte_idx !== idx && n < 1000) begin step(1); n++; end
    if (byte_idx !== idx) begin
      tests++; fails++;
      $display("FAIL %s_idx_timeout: got byte_idx %0d, expected %0d", name, byte_idx, idx);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, bad;
    logic [89:0] dA, dB, dC;
    vecs[0] = '{data: 90'h1,                          lat: LAT};
    vecs[1] = '{data: {90{1'b1}},                     lat: LAT};
    vecs[2] = '{data: 90'h3ABCDEF0123456789ABCDE,     lat: LAT};
    vecs[3] = '{data: 90'h2_5A5A_5A5A_5A5A_5A5A_5A5A_5A, lat: LAT};
    dA = 90'h0DE_ADBE_EF01_2345_6789_AB;
    dB = 90'h155_5555_5555_5555_5555_55;
    dC = 90'h0F0_F0F0_F0F0_F0F0_F0F0_F0;

    step(3);
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(UART_done), 0);
    chk("rst_byte_idx", int'(byte_idx), 0);
    reset = 1'b1;
    step(5);
    chk("idle_tx", int'(tx), 1);

    // Table vectors, back to back with a single low cycle on go between words.
    for (int i = 0; i < 4; i++) begin
      base = done_cnt;
      push_frame(vecs[i].data);
      request(vecs[i].data);
      wait_done($sformatf("vec%0d", i), vecs[i].lat);
      step(1);
      UART_go = 1'b0;
      step(1);
      chk($sformatf("vec%0d_sb_empty", i), sbq.size(), 0);
      chk($sformatf("vec%0d_done_count", i), done_cnt - base, 1);
    end

    // go held high after done must not start another frame.
    base = done_cnt;
    push_frame(dA);
    request(dA);
    wait_done("hold", LAT);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("hold_no_retrigger", bad, 0);
    chk("hold_done_count", done_cnt - base, 1);
    step(1);
    UART_go = 1'b0;
    step(1);
    push_frame(dB);
    request(dB);
    wait_done("rearm", LAT);
    step(1);
    UART_go = 1'b0;
    step(1);
    chk("rearm_sb_empty", sbq.size(), 0);

    // go dropped and data changed mid-frame: frame keeps LOAD-time word.
    base = done_cnt;
    push_frame(dC);
    request(dC);
    wait_idx("drop", 4'd5);
    data_in = ~dC;
    UART_go = 1'b0;
    wait_done("drop", LAT);
    step(2);
    chk("drop_busy_after", int'(busy), 0);
    chk("drop_tx_after", int'(tx), 1);
    step(50);
    chk("drop_done_count", done_cnt - base, 1);
    chk("drop_sb_empty", sbq.size(), 0);

    // Reset in the middle of byte 3.
    push_frame(dA);
    request(dA);
    wait_idx("rst", 4'd3);
    step(6);
    base = done_cnt;
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    UART_go = 1'b0;
    chk("midrst_tx", int'(tx), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_byte_idx", int'(byte_idx), 0);
    sbq.delete();
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    chk("midrst_tx_idle", bad, 0);
    chk("midrst_no_done", done_cnt - base, 0);
    step(1);
    push_frame(dB);
    request(dB);
    wait_done("post_rst", LAT);
    step(1);
    UART_go = 1'b0;
    step(1);
    chk("post_rst_sb_empty", sbq.size(), 0);
    chk("done_single_cycle", done_wide, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
